// File: rtl/poly_sub_stream.sv
// Streaming coefficient-wise modular subtraction c = (a - b) mod q.
// Two register stages with valid/ready handshaking on both sides.
module poly_sub_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int N_COEFF    = 256,
    parameter int IDX_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] q,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] c,
    output logic [IDX_WIDTH-1:0]  out_idx,
    output logic                  out_last,
    output logic                  range_err
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N_COEFF - 1);

    logic                  s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0] s1_a_q, s1_a_d;
    logic [DATA_WIDTH-1:0] s1_mod_q, s1_mod_d;
    logic [DATA_WIDTH:0]   s1_diff_q, s1_diff_d;
    logic                  s1_borrow_q, s1_borrow_d;
    logic                  s1_b_hi_q, s1_b_hi_d;

    logic                  s2_valid_q, s2_valid_d;
    logic [DATA_WIDTH-1:0] c_q, c_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;
    logic                  range_err_q, range_err_d;

    logic s2_load;
    logic accept;

    assign s2_load  = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_load;
    assign accept   = in_valid && in_ready;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_mod_d    = s1_mod_q;
        s1_diff_d   = s1_diff_q;
        s1_borrow_d = s1_borrow_q;
        s1_b_hi_d   = s1_b_hi_q;
        if (accept) begin
            s1_valid_d  = 1'b1;
            s1_a_d      = a;
            s1_mod_d    = q;
            s1_diff_d   = {1'b0, a} - {1'b0, b};
            s1_borrow_d = (a < b);
            s1_b_hi_d   = (b >= q);
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end
    end

    // The add-back is truncated to DATA_WIDTH; out-of-range inputs are not reduced.
    always_comb begin
        s2_valid_d  = s2_valid_q;
        c_d         = c_q;
        idx_d       = idx_q;
        range_err_d = range_err_q;
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                c_d = s1_borrow_q ? DATA_WIDTH'(s1_diff_q + {1'b0, s1_mod_q})
                                  : s1_diff_q[DATA_WIDTH-1:0];
            end
        end
        if (s2_valid_q && out_ready) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
        if (s1_valid_q && ((s1_a_q >= s1_mod_q) || s1_b_hi_q)) begin
            range_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_mod_q    <= '0;
            s1_diff_q   <= '0;
            s1_borrow_q <= 1'b0;
            s1_b_hi_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            c_q         <= '0;
            idx_q       <= '0;
            range_err_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_mod_q    <= s1_mod_d;
            s1_diff_q   <= s1_diff_d;
            s1_borrow_q <= s1_borrow_d;
            s1_b_hi_q   <= s1_b_hi_d;
            s2_valid_q  <= s2_valid_d;
            c_q         <= c_d;
            idx_q       <= idx_d;
            range_err_q <= range_err_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign c         = c_q;
    assign out_idx   = idx_q;
    assign out_last  = s2_valid_q && (idx_q == LAST_IDX);
    assign range_err = range_err_q;

endmodule
